// File: rtl/apb4_reg_slave.sv
// APB4 register-file slave: NUM_REGS word registers with per-register read-only
// and secure-only attributes, optional wait states and error signalling.
module apb4_reg_slave #(
    parameter int                           ADDR_W   = 32,
    parameter int                           DATA_W   = 32,
    parameter int                           NUM_REGS = 8,
    parameter int                           WAIT_CYC = 0,
    parameter logic [NUM_REGS-1:0]          RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]          SEC_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL  = '0
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic                       PWRITE,
    input  logic [ADDR_W-1:0]          PADDR,
    input  logic [DATA_W-1:0]          PWDATA,
    input  logic [DATA_W/8-1:0]        PSTRB,
    input  logic [2:0]                 PPROT,
    output logic [DATA_W-1:0]          PRDATA,
    output logic                       PREADY,
    output logic                       PSLVERR,
    output logic [NUM_REGS*DATA_W-1:0] reg_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BYTES-1:0]  strb_q;
    logic              nonsec_q;
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              setup;
    logic              access;
    logic              ready;
    logic              complete;
    logic [ADDR_W-1:0] index;
    logic [IDX_W-1:0]  idx_sel;
    logic              idx_ok;
    logic              err;
    logic              unused_prot;

    assign setup    = PSEL & ~PENABLE;
    assign access   = PSEL & PENABLE;
    assign ready    = (state == ACCESS) && (cnt == 4'd0);
    assign complete = ready & access;

    // Only the secure/non-secure bit of PPROT affects this slave.
    assign unused_prot = ^{PPROT[2], PPROT[0]};

    assign index   = addr_q >> OFF_W;
    assign idx_sel = index[IDX_W-1:0];
    assign idx_ok  = index < ADDR_W'(NUM_REGS);

    always_comb begin
        err = 1'b0;
        if (!idx_ok)                  err = 1'b1;
        if (|(addr_q & OFF_MASK))     err = 1'b1;
        if (!write_q && |strb_q)      err = 1'b1;
        if (idx_ok) begin
            if (write_q && RO_MASK[idx_sel])   err = 1'b1;
            if (nonsec_q && SEC_MASK[idx_sel]) err = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_next;
    end

    // An ACCESS without PSEL is an abort; without PENABLE it simply holds.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (setup) state_next = ACCESS;
            ACCESS:  if (!PSEL || complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        PREADY  = ready;
        PSLVERR = complete & err;
        PRDATA  = '0;
        if (complete && !write_q && !err) PRDATA = regs[idx_sel];
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                          cnt <= 4'd0;
        else if (state == IDLE && setup)       cnt <= 4'(WAIT_CYC);
        else if (state == ACCESS && access && cnt != 4'd0) cnt <= cnt - 4'd1;
    end

    always_ff @(posedge PCLK) begin
        if (state == IDLE && setup) begin
            addr_q   <= PADDR;
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
            strb_q   <= PSTRB;
            nonsec_q <= PPROT[1];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL[i*DATA_W +: DATA_W];
        end else if (complete && write_q && !err) begin
            for (int k = 0; k < BYTES; k++) begin
                if (strb_q[k]) regs[idx_sel][k*8 +: 8] <= wdata_q[k*8 +: 8];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
        assign reg_o[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Bench for apb4_reg_slave: three instances (0, 3 and 2 wait states) on a shared
// APB bus, checked against an array-based register model.
module tb_apb4_reg_slave;

    localparam int NR = 8;
    localparam logic [NR-1:0] RO  = 8'h80;
    localparam logic [NR-1:0] SEC = 8'h04;
    localparam logic [NR*32-1:0] RST = {32'hA5A5_0007, 32'h7777_7777, 32'hA5A5_0005,
                                        32'hA5A5_0004, 32'hA5A5_0003, 32'h5EC0_0002,
                                        32'hA5A5_0001, 32'h0000_0000};

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic [2:0]    psel;
    logic          PENABLE;
    logic          PWRITE;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [31:0]   prdata [3];
    logic          pready [3];
    logic          pslverr [3];
    logic [255:0]  rego [3];

    logic [31:0]   mdl [3][NR];
    int            n_cmp = 0;
    int            n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb4_reg_slave #(
            .ADDR_W(32), .DATA_W(32), .NUM_REGS(NR),
            .WAIT_CYC((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .RO_MASK(RO), .SEC_MASK(SEC), .RST_VAL(RST)
        ) u_dut (
            .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[g]), .PENABLE(PENABLE),
            .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
            .PPROT(PPROT), .PRDATA(prdata[g]), .PREADY(pready[g]),
            .PSLVERR(pslverr[g]), .reg_o(rego[g])
        );
    end

    always #5 PCLK = ~PCLK;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic logic [255:0] mvec(input int d);
        logic [255:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = mdl[d][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < NR; i++) mdl[d][i] = RST[i*32 +: 32];
    endtask

    // Applies one transfer to the model; returns the expected PRDATA and PSLVERR.
    task automatic model_apply(input int d, input logic wr, input logic [31:0] a,
                               input logic [31:0] data, input logic [3:0] s,
                               input logic [2:0] p, output logic [31:0] exp_rd,
                               output logic exp_err);
        int idx;
        idx = int'(a >> 2);
        exp_err = (idx >= NR) || (a[1:0] != 2'b00) || (!wr && s != 4'h0);
        if (!exp_err) exp_err = (wr && RO[idx]) || (SEC[idx] && p[1]);
        exp_rd = '0;
        if (!exp_err && !wr) exp_rd = mdl[d][idx];
        if (!exp_err && wr)
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[d][idx][k*8 +: 8] = data[k*8 +: 8];
    endtask

    // Setup + access phases; returns at the falling edge of the completion cycle
    // with the bus still driven, so a following call is back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a,
                        input logic [31:0] data, input logic [3:0] s, input logic [2:0] p,
                        output logic [31:0] rd, output logic er, output int waits,
                        output int bad);
        @(posedge PCLK); #1;
        psel = '0; psel[d] = 1'b1; PENABLE = 1'b0;
        PWRITE = wr; PADDR = a; PWDATA = data; PSTRB = s; PPROT = p;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = -1; bad = 0; rd = '0; er = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            if (pready[d]) begin
                rd = prdata[d]; er = pslverr[d]; waits = i;
                break;
            end
            if (prdata[d] !== 32'h0 || pslverr[d] !== 1'b0) bad++;
        end
    endtask

    task automatic idle();
        @(posedge PCLK); #1;
        psel = '0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0; PPROT = '0;
        @(negedge PCLK);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_cmp++; if (pready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready[%0d]: got %b want 0", d, pready[d]); end
            n_cmp++; if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr[%0d]: got %b want 0", d, pslverr[d]); end
            n_cmp++; if (prdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_prdata[%0d]: got %h want 0", d, prdata[d]); end
            n_cmp++; if (rego[d] !== RST) begin n_fail++; $display("FAIL reset_regs[%0d]: got %h want %h", d, rego[d], RST); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd; logic er, eer; int w, bad;
        model_apply(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, erd, eer);
        xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL wr_waits: got %0d want 0", w); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_pslverr: got %b want 0", er); end
        n_cmp++; if (rego[0] !== mvec(0)) begin n_fail++; $display("FAIL wr_regs: got %h want %h", rego[0], mvec(0)); end
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL rd_waits: got %0d want 0", w); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_pslverr: got %b want 0", er); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd, erd; logic er, eer; int w, bad;
        model_apply(0, 1'b1, 32'h4, 32'h11223344, 4'h5, 3'b000, erd, eer);
        xfer(0, 1'b1, 32'h4, 32'h11223344, 4'h5, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (rego[0][63:32] !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_reg1: got %h want de22be44", rego[0][63:32]); end
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_read: got %h want de22be44", rd); end
    endtask

    task automatic test_wait();
        logic [31:0] rd, erd; logic er, eer; int w, bad;
        model_apply(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, erd, eer);
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL wait3_waits: got %0d want 3", w); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL wait3_outputs_idle: got %0d nonzero cycles want 0", bad); end
        n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL wait3_data: got %h want %h", rd, erd); end
        model_apply(1, 1'b1, 32'hC, 32'h0BAD_CAFE, 4'hF, 3'b000, erd, eer);
        xfer(1, 1'b1, 32'hC, 32'h0BAD_CAFE, 4'hF, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL wait3_wr_waits: got %0d want 3", w); end
        n_cmp++; if (rego[1] !== mvec(1)) begin n_fail++; $display("FAIL wait3_regs: got %h want %h", rego[1], mvec(1)); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd, data; logic er, eer; int w, bad;
        logic        wr_t [9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
        logic [31:0] a_t  [9]  = '{32'h20, 32'h20, 32'h6, 32'h1C, 32'h8, 32'h8, 32'h4, 32'h8, 32'h1C};
        logic [3:0]  s_t  [9]  = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h1, 4'hF, 4'h0};
        logic [2:0]  p_t  [9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
        logic        e_t  [9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            data = $urandom | 32'h0101_0101;
            model_apply(0, wr_t[i], a_t[i], data, s_t[i], p_t[i], erd, eer);
            xfer(0, wr_t[i], a_t[i], data, s_t[i], p_t[i], rd, er, w, bad);
            idle();
            n_cmp++; if (er !== e_t[i]) begin n_fail++; $display("FAIL err_case%0d_pslverr: got %b want %b", i, er, e_t[i]); end
            n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL err_case%0d_prdata: got %h want %h", i, rd, erd); end
            n_cmp++; if (rego[0] !== mvec(0)) begin n_fail++; $display("FAIL err_case%0d_regs: got %h want %h", i, rego[0], mvec(0)); end
        end
    endtask

    task automatic test_no_setup();
        psel = '0; psel[0] = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR = 32'h0; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; PPROT = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            n_cmp++; if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL nosetup_pready%0d: got %b want 0", i, pready[0]); end
        end
        idle();
        n_cmp++; if (rego[0] !== mvec(0)) begin n_fail++; $display("FAIL nosetup_regs: got %h want %h", rego[0], mvec(0)); end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic er, eer; int w, bad;
        @(posedge PCLK); #1;
        psel = '0; psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 32'h10; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF; PPROT = 3'b000;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        n_cmp++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_early_pready: got %b want 0", pready[2]); end
        @(posedge PCLK); #1;
        psel = '0; PENABLE = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        n_cmp++; if (pready[2] !== 1'b0) begin n_fail++; $display("FAIL abort_pready: got %b want 0", pready[2]); end
        n_cmp++; if (rego[2] !== mvec(2)) begin n_fail++; $display("FAIL abort_regs: got %h want %h", rego[2], mvec(2)); end
        model_apply(2, 1'b1, 32'h14, 32'h1357_9BDF, 4'hF, 3'b000, erd, eer);
        xfer(2, 1'b1, 32'h14, 32'h1357_9BDF, 4'hF, 3'b000, rd, er, w, bad);
        idle();
        n_cmp++; if (w !== 2) begin n_fail++; $display("FAIL abort_next_waits: got %0d want 2", w); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL abort_next_pslverr: got %b want 0", er); end
        n_cmp++; if (rego[2] !== mvec(2)) begin n_fail++; $display("FAIL abort_next_regs: got %h want %h", rego[2], mvec(2)); end
    endtask

    task automatic test_random(input int n, input bit chain);
        logic [31:0] rd, erd, a, data; logic er, eer, wr; logic [3:0] s; logic [2:0] p;
        int d, w, bad;
        for (int i = 0; i < n; i++) begin
            d    = chain ? 0 : int'($urandom_range(0, 2));
            wr   = 1'($urandom);
            a    = chain ? ($urandom_range(0, 7) * 4) : $urandom_range(0, 39);
            data = $urandom;
            s    = wr ? 4'($urandom) : (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            p    = 3'($urandom);
            model_apply(d, wr, a, data, s, p, erd, eer);
            xfer(d, wr, a, data, s, p, rd, er, w, bad);
            n_cmp++; if (rd !== erd) begin n_fail++; $display("FAIL rand%0d_prdata: dut%0d addr %h got %h want %h", i, d, a, rd, erd); end
            n_cmp++; if (er !== eer) begin n_fail++; $display("FAIL rand%0d_pslverr: dut%0d addr %h got %b want %b", i, d, a, er, eer); end
            n_cmp++; if (w !== wait_of(d)) begin n_fail++; $display("FAIL rand%0d_waits: dut%0d got %0d want %0d", i, d, w, wait_of(d)); end
            n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rand%0d_wait_outputs: got %0d want 0", i, bad); end
            if (!chain && $urandom_range(0, 1) == 0) idle();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (rego[k] !== mvec(k)) begin n_fail++; $display("FAIL rand_regs[%0d]: got %h want %h", k, rego[k], mvec(k)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic er, eer; int w, bad;
        model_apply(1, 1'b1, 32'h0, 32'h2468_ACE0, 4'hF, 3'b000, erd, eer);
        xfer(1, 1'b1, 32'h0, 32'h2468_ACE0, 4'hF, 3'b000, rd, er, w, bad);
        idle();
        xfer(1, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 3'b000, rd, er, w, bad);
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL rstmid_waits: got %0d want 3", w); end
        #1 PRESETn = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_pready: got %b want 0", pready[1]); end
        n_cmp++; if (pslverr[1] !== 1'b0) begin n_fail++; $display("FAIL rstmid_pslverr: got %b want 0", pslverr[1]); end
        n_cmp++; if (prdata[1] !== 32'h0) begin n_fail++; $display("FAIL rstmid_prdata: got %h want 0", prdata[1]); end
        n_cmp++; if (rego[1] !== RST) begin n_fail++; $display("FAIL rstmid_regs: got %h want %h", rego[1], RST); end
        // Setup is already on the bus when reset releases; the first edge must take it.
        psel = '0; psel[1] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h10; PSTRB = 4'h0; PPROT = 3'b000;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        w = -1; rd = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (pready[1]) begin rd = prdata[1]; w = i; break; end
        end
        idle();
        n_cmp++; if (w !== 3) begin n_fail++; $display("FAIL rstrel_waits: got %0d want 3", w); end
        n_cmp++; if (rd !== RST[4*32 +: 32]) begin n_fail++; $display("FAIL rstrel_lost_write: got %h want %h", rd, RST[4*32 +: 32]); end
    endtask

    initial begin
        PRESETn = 1'b0; psel = '0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        model_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        test_reset();
        PRESETn = 1'b1;
        test_write_read();
        test_strobe();
        test_wait();
        test_errors();
        test_no_setup();
        test_abort();
        test_random(8, 1'b1);
        test_random(60, 1'b0);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb4_reg_slave.md
APB4_REG_SLAVE -- requirements
Module: apb4_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; legal values are 8, 16, 32, 64.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; legal range is 1..256.
REQ-004 SHALL have parameter WAIT_CYC, default 0, wait states inserted per transfer; legal range is 0..15.
REQ-005 SHALL have parameter RO_MASK [NUM_REGS-1:0], default 0; bit i=1 marks register i read-only.
REQ-006 SHALL have parameter SEC_MASK [NUM_REGS-1:0], default 0; bit i=1 marks register i secure-only.
REQ-007 SHALL have parameter RST_VAL [NUM_REGS*DATA_W-1:0], default 0, per-register reset values.
REQ-008 SHALL have ports, in this order:
  PCLK  in  1  the single clock; all logic on its rising edge.
  PRESETn  in  1  asynchronous, active-low reset.
  PSEL  in  1  slave select.
  PENABLE  in  1  access phase.
  PWRITE  in  1  1=write, 0=read.
  PADDR  in  ADDR_W  byte address.
  PWDATA  in  DATA_W  write data.
  PSTRB  in  DATA_W/8  write byte strobes.
  PPROT  in  3  protection; PPROT[1]=1 means non-secure.
  PRDATA  out  DATA_W  read data.
  PREADY  out  1  transfer complete.
  PSLVERR  out  1  transfer error.
  reg_o  out  NUM_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-009 Register index SHALL be PADDR >> log2(DATA_W/8); offset bits SHALL be PADDR[log2(DATA_W/8)-1:0].
REQ-010 FSM SHALL have two states: IDLE and ACCESS.
REQ-011 IDLE -> ACCESS when PSEL=1 and PENABLE=0 (setup phase); on that edge the block SHALL capture PADDR, PWRITE, PWDATA, PSTRB, PPROT and load wait counter = WAIT_CYC.
REQ-012 IDLE with PSEL=1 and PENABLE=1 (no setup phase) SHALL be ignored: no state change, PREADY=0.
REQ-013 In ACCESS with PSEL=1 and PENABLE=1, the counter SHALL decrement each cycle while nonzero.
REQ-014 PREADY SHALL be 1 exactly when state=ACCESS and counter=0; this is registered-state logic, not combinational from inputs.
REQ-015 With WAIT_CYC=0, PREADY SHALL assert in the first access cycle, giving zero wait states; with WAIT_CYC=N, PREADY SHALL assert in access cycle N+1.
REQ-016 Completion cycle is PSEL&PENABLE&PREADY; on its edge the FSM SHALL go to IDLE.
REQ-017 PSEL=0 while in ACCESS before completion (abort) SHALL return the FSM to IDLE with no register update.
REQ-018 Back-to-back: setup sampled in the cycle after completion SHALL start a new transfer with no idle cycle.
REQ-019 Error SHALL be flagged when any of these holds:
  - index >= NUM_REGS;
  - offset != 0;
  - write to a register with its RO_MASK bit set;
  - access to a register with its SEC_MASK bit set while PPROT[1]=1;
  - read with PSTRB != 0.
REQ-020 PSLVERR SHALL equal the error flag during the completion cycle and SHALL be 0 at all other times.
REQ-021 PRDATA SHALL be the addressed register on an error-free read completion and 0 at all other times, including on errors.
REQ-022 Error-free write SHALL update byte lane k of the addressed register only where PSTRB[k]=1, at the completion edge.
REQ-023 Errored or aborted writes SHALL leave all registers unchanged.
REQ-024 reg_o SHALL reflect updated contents in the cycle after the completion edge.

Reset
REQ-025 PRESETn=0 SHALL immediately (asynchronously) force: FSM=IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, every register=RST_VAL slice.
REQ-026 Reset asserted mid-transfer SHALL discard the transfer with no register write.
REQ-027 After PRESETn deasserts, the first setup phase accepted SHALL be on the first rising PCLK edge with PRESETn=1.

Verification
REQ-028 Bench SHALL cover: DATA_W=32, WAIT_CYC=0, write 0xDEADBEEF to addr 0x4 with PSTRB=0xF, then read 0x4 -> PREADY in first access cycle each time, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-029 Bench SHALL cover: reg1=0xDEADBEEF, write 0x11223344 to 0x4 with PSTRB=0x5 -> reg1=0xDE22BE44.
REQ-030 Bench SHALL cover: WAIT_CYC=3, read 0x0 -> PREADY=0 for 3 access cycles, 1 on the 4th.
REQ-031 Bench SHALL cover these error cases, each -> PSLVERR=1, PRDATA=0, no register change:
  - NUM_REGS=8, access 0x20;
  - access 0x6;
  - write to RO register;
  - SEC_MASK[2]=1, read 0x8 with PPROT=3'b010.
REQ-032 Bench SHALL cover: WAIT_CYC=2, write started, PSEL dropped before PREADY -> FSM IDLE, register unchanged; next transfer completes normally.
REQ-033 Bench SHALL cover: PRESETn pulsed low during a waited write -> outputs zero immediately, registers=RST_VAL, write lost.
